// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the instruction fetch queue.
package ins_fetch_queue_pkg;

  localparam logic        TRUE           = 1'b1;
  localparam logic        FALSE          = 1'b0;
  localparam int unsigned ZERO           = 0;
  localparam int unsigned DATA_IDX_RANGE = 32;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ins_fetch_queue_fifo.sv
// fetch_queue: parametrised synchronous FIFO with push, pop, flush, head data and count.
module fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [WIDTH-1:0]            din_i,
  output logic [WIDTH-1:0]            head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Depth is a power of two, so pointer increments wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch front end: HOLD/FETCH/DISCARD request FSM feeding a decoupling queue.
// Optional performance counters (fetch_cnt, flush_cnt) when IF_PERF_CNT_EN is defined.
module ins_fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   is_full,
  output logic                   rdy_to_fetch,
  output logic [ADDR_WIDTH-1:0]  pc_2icache,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr_from_icache,
  output logic                   valid_2pred,
  output logic [INSTR_WIDTH-1:0] instr_2pred,
  output logic [ADDR_WIDTH-1:0]  cur_pc,
  input  logic                   if_jump,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  output logic                   valid_2dsp,
  output logic                   if_jump_2dsp,
  output logic [ADDR_WIDTH-1:0]  pc_2dsp,
  output logic [INSTR_WIDTH-1:0] instr_2dsp,
  input  logic                   rollback_signal,
  input  logic [ADDR_WIDTH-1:0]  rollback_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  localparam int unsigned CW = cnt_width(QUEUE_DEPTH);
  localparam int unsigned EW = ADDR_WIDTH + INSTR_WIDTH + 1;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_2icache_q, pc_2icache_d;
  logic                  rdy_to_fetch_q, rdy_to_fetch_d;

  logic          q_push, q_pop, q_flush, q_full;
  logic [EW-1:0] q_din, q_head;
  logic [CW-1:0] q_count;

  assign q_full     = (q_count == CW'(QUEUE_DEPTH));
  assign valid_2dsp = (q_count != '0);
  assign q_din      = {pc_q, instr_from_icache, if_jump};

  assign valid_2pred = instr_valid;
  assign instr_2pred = instr_from_icache;
  assign cur_pc      = pc_q;

  assign rdy_to_fetch = rdy_to_fetch_q;
  assign pc_2icache   = pc_2icache_q;
  assign {pc_2dsp, instr_2dsp, if_jump_2dsp} = q_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HOLD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (rollback_signal) begin
        state_d = (state_q == FETCH) ? DISCARD : state_q;
      end else begin
        case (state_q)
          HOLD:    if (!q_full)     state_d = FETCH;
          FETCH:   if (instr_valid) state_d = HOLD;
          DISCARD: if (instr_valid) state_d = HOLD;
          default:                  state_d = HOLD;
        endcase
      end
    end
  end

  // Rollback leaves the i-cache strobe/address untouched so an in-flight request can drain.
  always_comb begin
    pc_d           = pc_q;
    pc_2icache_d   = pc_2icache_q;
    rdy_to_fetch_d = rdy_to_fetch_q;
    q_push         = FALSE;
    q_pop          = FALSE;
    q_flush        = FALSE;
    if (rdy) begin
      if (rollback_signal) begin
        pc_d    = rollback_pc;
        q_flush = TRUE;
      end else begin
        q_pop = valid_2dsp && !is_full;
        case (state_q)
          HOLD: begin
            if (!q_full) begin
              rdy_to_fetch_d = TRUE;
              pc_2icache_d   = pc_q;
            end else begin
              rdy_to_fetch_d = FALSE;
            end
          end
          FETCH: begin
            if (instr_valid) begin
              q_push         = TRUE;
              pc_d           = next_pc;
              rdy_to_fetch_d = FALSE;
            end
          end
          DISCARD: begin
            if (instr_valid) rdy_to_fetch_d = FALSE;
          end
          default: rdy_to_fetch_d = FALSE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q           <= '0;
      pc_2icache_q   <= '0;
      rdy_to_fetch_q <= FALSE;
    end else begin
      pc_q           <= pc_d;
      pc_2icache_q   <= pc_2icache_d;
      rdy_to_fetch_q <= rdy_to_fetch_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .din_i   (q_din),
    .head_o  (q_head),
    .count_o (q_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (q_push)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (rdy && rollback_signal) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed self-checking bench for ins_fetch_queue with a simple i-cache responder model.
module tb_ins_fetch_queue;

  logic        clk, rst, rdy, is_full;
  logic        rdy_to_fetch;
  logic [31:0] pc_2icache;
  logic        instr_valid;
  logic [31:0] instr_from_icache;
  logic        valid_2pred;
  logic [31:0] instr_2pred, cur_pc;
  logic        if_jump;
  logic [31:0] next_pc;
  logic        valid_2dsp, if_jump_2dsp;
  logic [31:0] pc_2dsp, instr_2dsp;
  logic        rollback_signal;
  logic [31:0] rollback_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  logic stall, pulse;
  int   checks, fails, cyc, acc;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic        pop_jmp[$];
  int          pop_cyc[$];

  ins_fetch_queue #(
    .QUEUE_DEPTH (4),
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .is_full           (is_full),
    .rdy_to_fetch      (rdy_to_fetch),
    .pc_2icache        (pc_2icache),
    .instr_valid       (instr_valid),
    .instr_from_icache (instr_from_icache),
    .valid_2pred       (valid_2pred),
    .instr_2pred       (instr_2pred),
    .cur_pc            (cur_pc),
    .if_jump           (if_jump),
    .next_pc           (next_pc),
    .valid_2dsp        (valid_2dsp),
    .if_jump_2dsp      (if_jump_2dsp),
    .pc_2dsp           (pc_2dsp),
    .instr_2dsp        (instr_2dsp),
    .rollback_signal   (rollback_signal),
    .rollback_pc       (rollback_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .flush_cnt         (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // i-cache returns pc^0x13; predictor says pc+4, jump only at pc 0x8.
  assign instr_from_icache = pc_2icache ^ 32'h13;
  assign next_pc           = cur_pc + 32'd4;
  assign if_jump           = (cur_pc == 32'h8);

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    instr_valid = (rdy_to_fetch && !stall) || pulse;
  end

  always @(negedge clk) begin
    if (rst && rdy && valid_2dsp && !is_full && !rollback_signal) begin
      pop_pc.push_back(pc_2dsp);
      pop_ins.push_back(instr_2dsp);
      pop_jmp.push_back(if_jump_2dsp);
      pop_cyc.push_back(cyc);
    end
    if (rst && rdy && instr_valid && rdy_to_fetch && !rollback_signal) acc = acc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pop_pc.delete();
    pop_ins.delete();
    pop_jmp.delete();
    pop_cyc.delete();
    acc = 0;
  endtask

  task automatic reset_release(input logic full);
    rst = 1'b0;
    stall = 1'b0;
    pulse = 1'b0;
    rdy = 1'b1;
    is_full = full;
    rollback_signal = 1'b0;
    tick();
    rst = 1'b1;
    clear_log();
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int i = 0; i < 60 && pop_pc.size() < n; i++) tick();
    check(tag, 64'(pop_pc.size() >= n), 64'd1);
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 60 && acc < n; i++) tick();
    check(tag, 64'(acc >= n), 64'd1);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0; acc = 0;
    rst = 1'b0; rdy = 1'b1; is_full = 1'b0; stall = 1'b0; pulse = 1'b0;
    instr_valid = 1'b0; rollback_signal = 1'b0; rollback_pc = '0;
    #3;
    check("rst_rdy_to_fetch", 64'(rdy_to_fetch), 64'd0);
    check("rst_pc_2icache", 64'(pc_2icache), 64'd0);
    check("rst_valid_2dsp", 64'(valid_2dsp), 64'd0);
    check("rst_pc_2dsp", 64'(pc_2dsp), 64'd0);
    check("rst_instr_2dsp", 64'(instr_2dsp), 64'd0);
    check("rst_if_jump_2dsp", 64'(if_jump_2dsp), 64'd0);
    check("rst_cur_pc", 64'(cur_pc), 64'd0);

    // Basic stream: 0x0, 0x4, 0x8 one every two cycles.
    reset_release(1'b0);
    tick();
    check("s1_req_strobe", 64'(rdy_to_fetch), 64'd1);
    check("s1_req_pc", 64'(pc_2icache), 64'h0);
    check("s1_valid_early", 64'(valid_2dsp), 64'd0);
    @(negedge clk);
    check("s1_pred_valid", 64'(valid_2pred), 64'd1);
    check("s1_pred_instr", 64'(instr_2pred), 64'h13);
    check("s1_pred_pc", 64'(cur_pc), 64'h0);
    tick();
    check("s1_latency_valid", 64'(valid_2dsp), 64'd1);
    check("s1_latency_pc", 64'(pc_2dsp), 64'h0);
    wait_pops(3, "s1_pop_timeout");
    if (pop_pc.size() >= 3) begin
      check("s1_pc0", 64'(pop_pc[0]), 64'h0);
      check("s1_pc1", 64'(pop_pc[1]), 64'h4);
      check("s1_pc2", 64'(pop_pc[2]), 64'h8);
      check("s1_instr0", 64'(pop_ins[0]), 64'h13);
      check("s1_instr2", 64'(pop_ins[2]), 64'h1b);
      check("s1_jump0", 64'(pop_jmp[0]), 64'd0);
      check("s1_jump2", 64'(pop_jmp[2]), 64'd1);
      check("s1_spacing", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
    end

    // Back-pressure: fill exactly four entries, then drain on consecutive cycles.
    reset_release(1'b1);
    for (int i = 0; i < 24; i++) tick();
    check("s2_push_count", 64'(acc), 64'd4);
    check("s2_strobe_off", 64'(rdy_to_fetch), 64'd0);
    check("s2_head_valid", 64'(valid_2dsp), 64'd1);
    check("s2_head_pc", 64'(pc_2dsp), 64'h0);
    check("s2_cur_pc", 64'(cur_pc), 64'h10);
    is_full = 1'b0;
    wait_pops(4, "s2_pop_timeout");
    if (pop_pc.size() >= 4) begin
      check("s2_pc0", 64'(pop_pc[0]), 64'h0);
      check("s2_pc1", 64'(pop_pc[1]), 64'h4);
      check("s2_pc2", 64'(pop_pc[2]), 64'h8);
      check("s2_pc3", 64'(pop_pc[3]), 64'hc);
      check("s2_back_to_back", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    end

    // Rollback while a fetch is outstanding.
    reset_release(1'b1);
    wait_acc(2, "s3_fill_timeout");
    stall = 1'b1;
    tick();
    check("s3_pending_strobe", 64'(rdy_to_fetch), 64'd1);
    check("s3_pending_pc", 64'(pc_2icache), 64'h8);
    rollback_signal = 1'b1; rollback_pc = 32'h100;
    tick();
    rollback_signal = 1'b0;
    check("s3_flushed", 64'(valid_2dsp), 64'd0);
    check("s3_strobe_held", 64'(rdy_to_fetch), 64'd1);
    check("s3_addr_held", 64'(pc_2icache), 64'h8);
    check("s3_cur_pc", 64'(cur_pc), 64'h100);
    tick(); tick();
    check("s3_strobe_held2", 64'(rdy_to_fetch), 64'd1);
    check("s3_addr_held2", 64'(pc_2icache), 64'h8);
    clear_log();
    stall = 1'b0; is_full = 1'b0;
    tick();
    check("s3_dropped", 64'(valid_2dsp), 64'd0);
    check("s3_strobe_drop", 64'(rdy_to_fetch), 64'd0);
    tick();
    check("s3_new_req", 64'(rdy_to_fetch), 64'd1);
    check("s3_new_pc", 64'(pc_2icache), 64'h100);
    wait_pops(1, "s3_pop_timeout");
    if (pop_pc.size() >= 1) check("s3_first_pc", 64'(pop_pc[0]), 64'h100);

    // Rollback coinciding with a push and a pop.
    reset_release(1'b1);
    wait_acc(2, "s4_fill_timeout");
    tick();
    check("s4_pending", 64'(rdy_to_fetch), 64'd1);
    is_full = 1'b0;
    rollback_signal = 1'b1; rollback_pc = 32'h200;
    clear_log();
    tick();
    rollback_signal = 1'b0;
    check("s4_count_zero", 64'(valid_2dsp), 64'd0);
    wait_pops(2, "s4_pop_timeout");
    if (pop_pc.size() >= 2) begin
      check("s4_pc0", 64'(pop_pc[0]), 64'h200);
      check("s4_pc1", 64'(pop_pc[1]), 64'h204);
    end

    // Reset mid-fetch, then freeze with rdy=0 for three cycles.
    stall = 1'b1;
    for (int i = 0; i < 10 && !rdy_to_fetch; i++) tick();
    check("s5_pending", 64'(rdy_to_fetch), 64'd1);
    rst = 1'b0;
    #2;
    check("s5_async_strobe", 64'(rdy_to_fetch), 64'd0);
    check("s5_async_pc", 64'(pc_2icache), 64'h0);
    check("s5_async_cur_pc", 64'(cur_pc), 64'h0);
    reset_release(1'b0);
    tick();
    check("s5_first_req", 64'(rdy_to_fetch), 64'd1);
    check("s5_first_pc", 64'(pc_2icache), 64'h0);
    for (int i = 0; i < 20 && !(valid_2dsp && pc_2dsp == 32'h4); i++) tick();
    rdy = 1'b0; pulse = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("s5_frz_valid", 64'(valid_2dsp), 64'd1);
      check("s5_frz_pc_2dsp", 64'(pc_2dsp), 64'h4);
      check("s5_frz_instr", 64'(instr_2dsp), 64'h17);
      check("s5_frz_strobe", 64'(rdy_to_fetch), 64'd0);
      check("s5_frz_pc_2icache", 64'(pc_2icache), 64'h4);
      check("s5_frz_cur_pc", 64'(cur_pc), 64'h8);
      rollback_signal = (k == 1);
      rollback_pc = 32'h300;
      tick();
    end
    rollback_signal = 1'b0;
    check("s5_frz_end_pc", 64'(cur_pc), 64'h8);
    rdy = 1'b1; pulse = 1'b0;
    wait_pops(4, "s5_pop_timeout");
    if (pop_pc.size() >= 4) begin
      check("s5_pc0", 64'(pop_pc[0]), 64'h0);
      check("s5_pc1", 64'(pop_pc[1]), 64'h4);
      check("s5_pc2", 64'(pop_pc[2]), 64'h8);
      check("s5_pc3", 64'(pop_pc[3]), 64'hc);
    end
`ifdef IF_PERF_CNT_EN
    check("s5_fetch_cnt", 64'(fetch_cnt), 64'(acc));
    check("s5_flush_cnt0", 64'(flush_cnt), 64'd0);
    rollback_signal = 1'b1; rollback_pc = 32'h400;
    tick();
    rollback_signal = 1'b0;
    check("s5_flush_cnt1", 64'(flush_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
